// File: rtl/reqack_responder.sv
// reqack_responder: request/acknowledge responder feeding the protocol checker.
// An accepted req starts a transaction with latency L = clamp(cfg_lat, 1, MAX_LAT):
// ack pulse, then done pulse on the following cycle, then a sticky intrpt
// INTR_DLY cycles after done. All handshake outputs are registered.
module reqack_responder #(
   parameter int MAX_LAT  = 5,
   parameter int INTR_DLY = 1,
   parameter int LAT_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [LAT_W-1:0] cfg_lat,
   input  logic             intr_clr,
   output logic             ack,
   output logic             done,
   output logic             intrpt,
   output logic             busy,
   output logic             req_drop
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [LAT_W-1:0] LAT_ONE = LAT_W'(1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(MAX_LAT);
   localparam logic [1:0]       DLY_SEL = 2'(INTR_DLY);

   state_t           state_r;
   state_t           next_s;
   logic [LAT_W-1:0] cnt_r;
   logic [LAT_W-1:0] lat_s;
   logic             ack_s;
   logic             done_s;
   logic             busy_s;
   logic             drop_s;
   logic [2:0]       dly_r;
   logic             start_s;
   logic             set_s;
   logic             ack_r;
   logic             done_r;
   logic             busy_r;
   logic             drop_r;
   logic             intrpt_r;

   // Parameter sanity check at elaboration; synthesis ignores this block.
   initial begin
      if (MAX_LAT < 1 || MAX_LAT > 15) begin
         $error("reqack_responder: MAX_LAT=%0d outside 1..15", MAX_LAT);
      end
      if (INTR_DLY < 0 || INTR_DLY > 3) begin
         $error("reqack_responder: INTR_DLY=%0d outside 0..3", INTR_DLY);
      end
   end

   // Clamp the requested latency into 1..MAX_LAT.
   always_comb begin
      lat_s = cfg_lat;
      if (cfg_lat == {LAT_W{1'b0}}) begin
         lat_s = LAT_ONE;
      end else if (cfg_lat > LAT_MAX) begin
         lat_s = LAT_MAX;
      end else begin
         lat_s = cfg_lat;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // FSM next-state logic; L = 1 skips the wait state entirely.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (req) begin
               next_s = (lat_s == LAT_ONE) ? ST_ACK : ST_WAIT;
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == LAT_ONE) begin
               next_s = ST_ACK;
            end else begin
               next_s = ST_WAIT;
            end
         end
         ST_ACK:  next_s = ST_DONE;
         ST_DONE: next_s = ST_IDLE;
         default: next_s = ST_IDLE;
      endcase
   end

   // Latency counter: loaded with L-1 on acceptance, counts down while waiting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= {LAT_W{1'b0}};
      end else if (state_r == ST_IDLE && req) begin
         cnt_r <= lat_s - LAT_ONE;
      end else if (state_r == ST_WAIT) begin
         cnt_r <= cnt_r - LAT_ONE;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // FSM output decode from the next state so the registered outputs line up with it.
   always_comb begin
      ack_s  = (next_s == ST_ACK);
      done_s = (next_s == ST_DONE);
      busy_s = (next_s != ST_IDLE);
      drop_s = req && (state_r != ST_IDLE);
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_r  <= 1'b0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
         drop_r <= 1'b0;
      end else begin
         ack_r  <= ack_s;
         done_r <= done_s;
         busy_r <= busy_s;
         drop_r <= drop_s;
      end
   end

   // Interrupt delay line start point: the edge that moves the FSM out of ACK.
   always_comb begin
      start_s = (state_r == ST_ACK);
   end

   // Interrupt delay line; a shift register so overlapping transactions each land.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dly_r <= 3'b000;
      end else begin
         dly_r <= {dly_r[1:0], start_s};
      end
   end

   // Tap the delay line at the configured depth.
   always_comb begin
      case (DLY_SEL)
         2'd0:    set_s = start_s;
         2'd1:    set_s = dly_r[0];
         2'd2:    set_s = dly_r[1];
         default: set_s = dly_r[2];
      endcase
   end

   // Sticky interrupt; a set in the same cycle as a clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         intrpt_r <= 1'b0;
      end else if (set_s) begin
         intrpt_r <= 1'b1;
      end else if (intr_clr) begin
         intrpt_r <= 1'b0;
      end else begin
         intrpt_r <= intrpt_r;
      end
   end

   assign ack      = ack_r;
   assign done     = done_r;
   assign busy     = busy_r;
   assign req_drop = drop_r;
   assign intrpt   = intrpt_r;

endmodule
